// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM Avalon-MM arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {IDLE, CMD} state_t;

  // 0 = display fetch engine, 1 = sprite blitter
  typedef logic port_id_t;

endpackage

// File: rtl/sdram_mm_arbiter_if.sv
// Avalon-MM SDRAM slave bus as seen from the arbiter (master) and the memory (slave).
interface sdram_mm_arbiter_if;

  logic [sdram_arb_pkg::ADDR_W-1:0] address;
  logic [sdram_arb_pkg::BE_W-1:0]   byteenable_n;
  logic                             chipselect;
  logic [sdram_arb_pkg::DATA_W-1:0] writedata;
  logic                             read_n;
  logic                             write_n;
  logic [sdram_arb_pkg::DATA_W-1:0] readdata;
  logic                             readdatavalid;
  logic                             waitrequest;

  modport master (
    output address, byteenable_n, chipselect, writedata, read_n, write_n,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable_n, chipselect, writedata, read_n, write_n,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO remembering which port issued each outstanding read, in issue order.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output port_id_t head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  port_id_t               mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   wr_en;
  logic                   rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // NOTE: storage is not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      count <= count + CNT_W'(1);
      else if (rd_en && !wr_en) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_mm_arbiter.sv
// Shares one Avalon-MM SDRAM slave between the display fetch (port 0) and the blitter (port 1).
module sdram_mm_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [BE_W-1:0]   m1_be_n,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,

  sdram_mm_arbiter_if.master sdram_mm,
  output logic              err
);

  state_t            state;
  port_id_t          grant;
  logic [3:0]        starve_cnt;

  logic [ADDR_W-1:0] address_q;
  logic [BE_W-1:0]   be_n_q;
  logic              cs_q;
  logic [DATA_W-1:0] wdata_q;
  logic              read_n_q;
  logic              write_n_q;

  port_id_t          fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  logic              elig0;
  logic              elig1;
  logic              pick1;
  logic              accept;
  logic              rd_pop;

  assign sdram_mm.address      = address_q;
  assign sdram_mm.byteenable_n = be_n_q;
  assign sdram_mm.chipselect   = cs_q;
  assign sdram_mm.writedata    = wdata_q;
  assign sdram_mm.read_n       = read_n_q;
  assign sdram_mm.write_n      = write_n_q;

  // A read may only be issued while a tag slot is free; writes never need one.
  assign elig0  = m0_req && !fifo_full;
  assign elig1  = m1_req && (m1_we || !fifo_full);
  assign pick1  = elig1 && (!elig0 || (starve_cnt >= 4'(STARVE_LIMIT)));

  assign accept = (state == CMD) && cs_q && !sdram_mm.waitrequest;
  assign m0_ack = accept && (grant == 1'b0);
  assign m1_ack = accept && (grant == 1'b1);
  assign rd_pop = sdram_mm.readdatavalid && !fifo_empty;

  sdram_arb_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (accept && !read_n_q),
    .push_id (grant),
    .pop     (sdram_mm.readdatavalid),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      starve_cnt <= '0;
      address_q  <= '0;
      be_n_q     <= '1;
      cs_q       <= 1'b0;
      wdata_q    <= '0;
      read_n_q   <= 1'b1;
      write_n_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick1) begin
            grant      <= 1'b1;
            starve_cnt <= '0;
            cs_q       <= 1'b1;
            address_q  <= m1_addr;
            if (m1_we) begin
              write_n_q <= 1'b0;
              be_n_q    <= m1_be_n;
              wdata_q   <= m1_wdata;
            end else begin
              read_n_q  <= 1'b0;
              be_n_q    <= '0;
            end
            state <= CMD;
          end else if (elig0) begin
            grant <= 1'b0;
            if (elig1) starve_cnt <= starve_cnt + 4'd1;
            cs_q      <= 1'b1;
            address_q <= m0_addr;
            read_n_q  <= 1'b0;
            be_n_q    <= '0;
            state     <= CMD;
          end
        end
        CMD: begin
          // Bus stays frozen until the slave drops waitrequest.
          if (accept) begin
            cs_q      <= 1'b0;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      m0_rdata  <= '0;
      m0_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_rvalid <= 1'b0;
      err       <= 1'b0;
    end else begin
      m0_rvalid <= rd_pop && (fifo_head == 1'b0);
      m1_rvalid <= rd_pop && (fifo_head == 1'b1);
      if (rd_pop && (fifo_head == 1'b0)) m0_rdata <= sdram_mm.readdata;
      if (rd_pop && (fifo_head == 1'b1)) m1_rdata <= sdram_mm.readdata;
      // Orphan beat: no read outstanding to own it.
      if (sdram_mm.readdatavalid && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_mm_arbiter.sv
// Scenario bench for sdram_mm_arbiter with a read-return scoreboard.
module tb_sdram_mm_arbiter;
  import sdram_arb_pkg::*;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b1;
  logic              m0_req = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_rvalid;
  logic              m1_req = 1'b0;
  logic              m1_we = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic [BE_W-1:0]   m1_be_n = '1;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_rvalid;
  logic              err;

  sdram_mm_arbiter_if sdram_mm();

  sdram_mm_arbiter #(.MAX_PENDING(4), .STARVE_LIMIT(3)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .m0_req        (m0_req),
    .m0_addr       (m0_addr),
    .m0_ack        (m0_ack),
    .m0_rdata      (m0_rdata),
    .m0_rvalid     (m0_rvalid),
    .m1_req        (m1_req),
    .m1_we         (m1_we),
    .m1_addr       (m1_addr),
    .m1_wdata      (m1_wdata),
    .m1_be_n       (m1_be_n),
    .m1_ack        (m1_ack),
    .m1_rdata      (m1_rdata),
    .m1_rvalid     (m1_rvalid),
    .sdram_mm      (sdram_mm),
    .err           (err)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    port_id_t          port;
    logic [DATA_W-1:0] data;
  } beat_t;

  int       checks   = 0;
  int       failures = 0;
  beat_t    exp_q[$];
  port_id_t tag_model[$];

  // Monitor: records accepted reads and scores every rvalid beat in order.
  always @(negedge clk_clk) begin
    beat_t e;
    if (reset_reset_n) begin
      if (sdram_mm.chipselect && !sdram_mm.waitrequest) begin
        checks++;
        if ((m0_ack ^ m1_ack) !== 1'b1) begin
          failures++;
          $display("FAIL ack_onehot m0_ack=%b m1_ack=%b", m0_ack, m1_ack);
        end
        if (!sdram_mm.read_n) begin
          tag_model.push_back(m1_ack);
          checks++;
          if (sdram_mm.byteenable_n !== 4'h0) begin
            failures++;
            $display("FAIL read_be got=%h exp=0", sdram_mm.byteenable_n);
          end
        end
      end
      if (m0_rvalid || m1_rvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected m0_rvalid=%b m1_rvalid=%b", m0_rvalid, m1_rvalid);
        end else begin
          e = exp_q.pop_front();
          if (m1_rvalid !== e.port || m0_rvalid !== !e.port ||
              (e.port ? m1_rdata : m0_rdata) !== e.data) begin
            failures++;
            $display("FAIL sb_beat got=%b%b/%h exp_port=%0d data=%h", m1_rvalid, m0_rvalid,
                     e.port ? m1_rdata : m0_rdata, e.port, e.data);
          end
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk_clk); #1;
  endtask

  task automatic drive_edge();
    @(posedge clk_clk); #1;
  endtask

  function automatic void arm(input logic [DATA_W-1:0] d);
    port_id_t p;
    if (tag_model.size() > 0) begin
      p = tag_model.pop_front();
      exp_q.push_back({p, d});
    end
  endfunction

  // One readdatavalid beat; rvalid is checked on the cycle after it.
  task automatic do_beat(input logic [DATA_W-1:0] d);
    logic     had;
    port_id_t p;
    had = (tag_model.size() > 0);
    p   = had ? tag_model[0] : 1'b0;
    arm(d);
    drive_edge();
    sdram_mm.readdatavalid = 1'b1;
    sdram_mm.readdata      = d;
    drive_edge();
    sdram_mm.readdatavalid = 1'b0;
    sample();
    checks++;
    if (had) begin
      if ((p ? m1_rvalid : m0_rvalid) !== 1'b1 || (p ? m0_rvalid : m1_rvalid) !== 1'b0 ||
          (p ? m1_rdata : m0_rdata) !== d) begin
        failures++;
        $display("FAIL beat_route port=%0d rvalid=%b%b rdata=%h exp=%h", p, m1_rvalid, m0_rvalid,
                 p ? m1_rdata : m0_rdata, d);
      end
    end else if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL orphan_beat rvalid=%b%b err=%b exp rvalid=00 err=1", m1_rvalid, m0_rvalid, err);
    end
  endtask

  task automatic issue(input port_id_t p, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
    logic got;
    got = 1'b0;
    drive_edge();
    if (p) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd; m1_be_n = be;
    end else begin
      m0_req = 1'b1; m0_addr = a;
    end
    for (int i = 0; i < 40; i++) begin
      sample();
      if (p ? m1_ack : m0_ack) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL issue_timeout port=%0d addr=%h got=no_ack exp=ack", p, a);
    end
    drive_edge();
    if (p) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({sdram_mm.chipselect, sdram_mm.read_n, sdram_mm.write_n, sdram_mm.byteenable_n,
         sdram_mm.address, sdram_mm.writedata} !== {1'b0, 1'b1, 1'b1, 4'hF, 25'h0, 32'h0}) begin
      failures++;
      $display("FAIL %s_bus cs=%b rd_n=%b wr_n=%b be_n=%h addr=%h wdata=%h exp 0/1/1/f/0/0", name,
               sdram_mm.chipselect, sdram_mm.read_n, sdram_mm.write_n, sdram_mm.byteenable_n,
               sdram_mm.address, sdram_mm.writedata);
    end
    checks++;
    if ({m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, err} !== '0) begin
      failures++;
      $display("FAIL %s_ports acks=%b%b rvalid=%b%b rdata=%h/%h err=%b exp all 0", name, m0_ack,
               m1_ack, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, err);
    end
  endtask

  task automatic test_reset();
    sdram_mm.readdata      = '0;
    sdram_mm.readdatavalid = 1'b0;
    sdram_mm.waitrequest   = 1'b0;
    #2 reset_reset_n = 1'b0;
    drive_edge();
    drive_edge();
    check_reset_values("reset");
    reset_reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    drive_edge();
    m0_req = 1'b1; m0_addr = 25'h0000100;
    sample();
    checks++;
    if (sdram_mm.chipselect !== 1'b0) begin
      failures++;
      $display("FAIL read_early cs=%b exp=0", sdram_mm.chipselect);
    end
    sample();
    checks++;
    if ({sdram_mm.chipselect, sdram_mm.read_n, sdram_mm.write_n, sdram_mm.address,
         sdram_mm.byteenable_n, m0_ack, m1_ack} !== {3'b101, 25'h0000100, 4'h0, 2'b10}) begin
      failures++;
      $display("FAIL read_cmd cs=%b rd_n=%b wr_n=%b addr=%h be_n=%h ack=%b%b exp 1/0/1/100/0/10",
               sdram_mm.chipselect, sdram_mm.read_n, sdram_mm.write_n, sdram_mm.address,
               sdram_mm.byteenable_n, m0_ack, m1_ack);
    end
    drive_edge();
    m0_req = 1'b0;
    sample();
    checks++;
    if (sdram_mm.chipselect !== 1'b0 || m0_ack !== 1'b0) begin
      failures++;
      $display("FAIL cs_off_cycle cs=%b ack=%b exp 0/0", sdram_mm.chipselect, m0_ack);
    end
    drive_edge();
    do_beat(32'hDEADBEEF);
  endtask

  task automatic test_write_wait();
    drive_edge();
    sdram_mm.waitrequest = 1'b1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 25'h1FFFFFF; m1_wdata = 32'h12345678; m1_be_n = 4'h3;
    for (int i = 1; i <= 6; i++) begin
      drive_edge();
      if (i == 6) sdram_mm.waitrequest = 1'b0;
      sample();
      checks++;
      if ({sdram_mm.chipselect, sdram_mm.read_n, sdram_mm.write_n, sdram_mm.byteenable_n,
           sdram_mm.address, sdram_mm.writedata} !== {3'b110, 4'h3, 25'h1FFFFFF, 32'h12345678}) begin
        failures++;
        $display("FAIL write_hold cycle=%0d cs=%b rd_n=%b wr_n=%b be_n=%h addr=%h wdata=%h", i,
                 sdram_mm.chipselect, sdram_mm.read_n, sdram_mm.write_n, sdram_mm.byteenable_n,
                 sdram_mm.address, sdram_mm.writedata);
      end
      checks++;
      if (m1_ack !== (i == 6) || m0_ack !== 1'b0) begin
        failures++;
        $display("FAIL write_ack cycle=%0d m1_ack=%b m0_ack=%b exp %b/0", i, m1_ack, m0_ack, i == 6);
      end
    end
    drive_edge();
    m1_req = 1'b0;
    sample();
    checks++;
    if (sdram_mm.chipselect !== 1'b0 || sdram_mm.write_n !== 1'b1) begin
      failures++;
      $display("FAIL write_release cs=%b wr_n=%b exp 0/1", sdram_mm.chipselect, sdram_mm.write_n);
    end
  endtask

  task automatic test_starvation();
    logic       got [8];
    logic       exp_g [8];
    logic       beat_next;
    int         n;
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    beat_next = 1'b0;
    n = 0;
    drive_edge();
    m0_req = 1'b1; m0_addr = 25'h0000200;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 25'h0000300; m1_wdata = 32'hCAFE0000; m1_be_n = 4'h0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      sample();
      if (m0_ack || m1_ack) begin
        got[n] = m1_ack;
        n++;
        if (m0_ack) beat_next = 1'b1;
      end
      drive_edge();
      sdram_mm.readdatavalid = beat_next;
      if (beat_next) begin
        sdram_mm.readdata = 32'h5000 + 32'(n);
        arm(sdram_mm.readdata);
      end
      beat_next = 1'b0;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    sdram_mm.readdatavalid = 1'b0;
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL starve_count grants=%0d exp=8", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp_g[i]) begin
        failures++;
        $display("FAIL starve_seq idx=%0d got=%0d exp=%0d", i, got[i], exp_g[i]);
      end
    end
    repeat (3) drive_edge();
  endtask

  task automatic test_order();
    issue(1'b0, 1'b0, 25'h0000010, '0, 4'h0);
    issue(1'b1, 1'b0, 25'h0000020, '0, 4'h0);
    issue(1'b0, 1'b0, 25'h0000030, '0, 4'h0);
    do_beat(32'h0000000A);
    do_beat(32'h0000000B);
    do_beat(32'h0000000C);
  endtask

  task automatic test_full();
    logic got;
    logic bad;
    got = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b0, 25'h0000040 + 25'(i), '0, 4'h0);
    drive_edge();
    m0_req = 1'b1; m0_addr = 25'h0000055;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 25'h0000066; m1_wdata = 32'h66666666; m1_be_n = 4'h0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (m0_ack) bad = 1'b1;
      if (m1_ack) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || bad) begin
      failures++;
      $display("FAIL full_write_bypass m1_acked=%b m0_acked=%b exp 1/0", got, bad);
    end
    drive_edge();
    m1_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (sdram_mm.chipselect !== 1'b0) begin
        failures++;
        $display("FAIL full_blocks_read cycle=%0d cs=%b exp=0", i, sdram_mm.chipselect);
      end
    end
    do_beat(32'h0000F001);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (m0_ack) begin
        got = (sdram_mm.address === 25'h0000055);
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL full_release addr=%h got_ack=%b exp 55/1", sdram_mm.address, m0_ack);
    end
    drive_edge();
    m0_req = 1'b0;
    for (int i = 2; i <= 5; i++) do_beat(32'h0000F000 + 32'(i));
  endtask

  task automatic test_err_and_reset();
    do_beat(32'h00000BAD);
    repeat (3) drive_edge();
    sample();
    checks++;
    if (err !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky err=%b rvalid=%b%b exp 1/00", err, m1_rvalid, m0_rvalid);
    end
    drive_edge();
    sdram_mm.waitrequest = 1'b1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 25'h0000077; m1_wdata = 32'h77777777; m1_be_n = 4'h5;
    sample();
    sample();
    checks++;
    if (sdram_mm.chipselect !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup cs=%b exp=1", sdram_mm.chipselect);
    end
    reset_reset_n = 1'b0;
    #1;
    check_reset_values("reset_in_cmd");
    exp_q.delete();
    tag_model.delete();
    m1_req = 1'b0;
    sdram_mm.waitrequest = 1'b0;
    drive_edge();
    reset_reset_n = 1'b1;
    do_beat(32'h00000001);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_starvation();
    test_order();
    test_full();
    test_err_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_mm_arbiter.md
# sdram_mm_arbiter

Two-port arbiter that shares the single Avalon-MM SDRAM slave port (`sdram_mm_*`) of the Nios system between the display fetch engine (read-only, port 0) and the sprite blitter (read/write, port 1). It serializes commands onto the slave and honours `waitrequest`. It tracks outstanding pipelined reads in a tag FIFO, so each `readdatavalid` beat is routed back to the requester that issued it. It sits in the top level between the two hardware engines and the `nios_system` SDRAM master-side pins.

## Interface
- `MAX_PENDING`, 4: maximum outstanding reads; power of two, 2..16.
- `STARVE_LIMIT`, 3: consecutive port-0 grants allowed while port 1 is waiting; 1..15.
- `clk_clk`  in  1  system clock, single clock domain.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `m0_req`  in  1  port-0 read request; held with `m0_addr` until `m0_ack`.
- `m0_addr`  in  25  port-0 word address.
- `m0_ack`  out  1  port-0 command accepted this cycle.
- `m0_rdata`  out  32  port-0 read data.
- `m0_rvalid`  out  1  `m0_rdata` is valid this cycle.
- `m1_req`, `m1_we`  in  1 each  port-1 request; `m1_we` = 1 selects a write.
- `m1_addr`  in  25  port-1 word address.
- `m1_wdata`  in  32  port-1 write data.
- `m1_be_n`  in  4  port-1 byte enables, active-low.
- `m1_ack`, `m1_rvalid`  out  1 each  port-1 accept / read-data valid.
- `m1_rdata`  out  32  port-1 read data.
- `sdram_mm_address`  out  25; `sdram_mm_byteenable_n`  out  4; `sdram_mm_chipselect`  out  1.
- `sdram_mm_writedata`  out  32; `sdram_mm_read_n`  out  1; `sdram_mm_write_n`  out  1.
- `sdram_mm_readdata`  in  32; `sdram_mm_readdatavalid`  in  1; `sdram_mm_waitrequest`  in  1.
- `err`  out  1  sticky protocol error: `readdatavalid` arrived with no read outstanding.

## Operation
- FSM has two states.
  - IDLE: arbitrate, latch the winner's command into output registers, go to CMD.
  - CMD: hold every bus output stable. On `chipselect && !waitrequest` the command is accepted: return to IDLE and drive a chipselect-off cycle.
- Eligibility:
  - Port 0 is eligible when `m0_req` is high and the tag FIFO is not full.
  - Port 1 is eligible when `m1_req` is high and either `m1_we` = 1 or the FIFO is not full.
- Priority: port 0 wins by default. A 4-bit starvation counter increments on each port-0 grant made while port 1 is eligible. When the counter reaches `STARVE_LIMIT`, port 1 wins the next arbitration and the counter clears. The counter also clears on any port-1 grant.
- `mX_ack` is combinational: `state==CMD && grant==X && !sdram_mm_waitrequest`. The requester may change `req`/`addr` at that edge.
- An accepted read pushes the grant id (1 bit) into the tag FIFO.
- `readdatavalid` pops the FIFO head. The registered `m<head>_rdata` / `m<head>_rvalid` are asserted the next cycle. The other port's rvalid stays 0.
- Push and pop in the same cycle are both performed; the count is unchanged. `full` is evaluated before the pop.
- `readdatavalid` with the FIFO empty: data is dropped, no rvalid is asserted, `err` is set and stays 1 until reset.
- Reset asynchronously clears the FSM, FIFO, counter and `err`. Reads outstanding at reset are abandoned; a late `readdatavalid` for one of them sets `err`.

## Timing
- Reset values:
  - `chipselect`=0, `read_n`=1, `write_n`=1, `byteenable_n`=4'hF.
  - `address`=0, `writedata`=0.
  - `m0_ack`, `m1_ack`, `m0_rvalid`, `m1_rvalid` = 0; `m0_rdata`, `m1_rdata` = 0; `err`=0.
- Request high in IDLE at edge k: the command is on the bus from edge k+1. With `waitrequest` low, ack is high in cycle k+1 and the state is IDLE at edge k+2.
- Peak throughput: one command per 2 cycles.
- Reads drive `byteenable_n`=4'h0.
- Read data latency: rvalid is 1 cycle after `readdatavalid`.
- Ordering: reads complete in issue order, with no reordering across ports.

## Structure
- Package `sdram_arb_pkg` holds:
  - constants ADDR_W=25, DATA_W=32, BE_W=4;
  - `state_t` enum {IDLE, CMD};
  - `port_id_t` (1 bit).
- Sub-module `sdram_arb_tag_fifo`: synchronous FIFO of `port_id_t`, depth `MAX_PENDING`, with push, pop, head, full and empty.

## Test plan
- Port-0 read of 0x0000100; slave returns 0xDEADBEEF 3 cycles after accept -> `m0_rvalid`=1 with 0xDEADBEEF one cycle after `readdatavalid`; `m1_rvalid` stays 0.
- Port-1 write of 0x12345678 to 0x1FFFFFF with `be_n`=4'h3; `waitrequest` high for 5 cycles -> bus signals stable throughout, `write_n` low for 6 cycles, `m1_ack` high only in the accept cycle.
- Both ports requesting continuously, `STARVE_LIMIT`=3 -> grant sequence 0,0,0,1,0,0,0,1.
- Reads issued in the order m0, m1, m0; then three `readdatavalid` beats (0xA, 0xB, 0xC) -> `m0_rdata`=0xA, `m1_rdata`=0xB, `m0_rdata`=0xC, in order.
- Four reads outstanding with `MAX_PENDING`=4 -> a fifth m0 read is not issued (`chipselect`=0), while a pending m1 write is still issued. After one `readdatavalid`, the m0 read issues.
- `readdatavalid` with the FIFO empty -> `err`=1 and stays 1, no rvalid. Asserting reset during CMD -> all outputs at reset values immediately and `err`=0.
